// File: rtl/bus_rr_arbiter_pkg.sv
// Shared defaults and FSM encoding for the round-robin bus arbiter.
package bus_rr_arbiter_pkg;

  localparam int N_BUS_DEF   = 15;
  localparam int SEL_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage : bus_rr_arbiter_pkg

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the polled channels, the arbiter and the downstream mux.
interface bus_rr_arbiter_if
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_BUS = N_BUS_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic [N_BUS-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic             en_sel;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req, done,
    input  sel, en_sel, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output sel, en_sel, busy, timeout_err
  );

endinterface : bus_rr_arbiter_if

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, with wrap.
module rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_BUS = N_BUS_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_BUS-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] winner,
  output logic             any_valid
);

  localparam int IDX_W = $clog2(N_BUS);

  logic [SEL_W-1:0] idx;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no path leaves it unassigned (no inferred latch).
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_BUS; i++) begin
      idx = start + SEL_W'(i);
      if (idx >= SEL_W'(N_BUS)) idx = idx - SEL_W'(N_BUS);
      if (!any_valid && req[idx[IDX_W-1:0]]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: grants one bus channel at a time, holds it until done or timeout.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_BUS   = N_BUS_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  bus_rr_arbiter_if.slave  bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_BUS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;

  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] winner;
  logic             any_valid;

  assign start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

  rr_pick #(
    .N_BUS (N_BUS),
    .SEL_W (SEL_W)
  ) u_pick (
    .req       (bus.req),
    .start     (start),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_IDX;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  // Outputs are registered: the _d values below become visible the cycle after the decision.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (any_valid) begin
          sel_d   = winner;
          last_d  = winner;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        // done takes priority over an expiry in the same cycle
        if (bus.done) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          busy_d  = 1'b0;
          terr_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.en_sel      = en_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule : bus_rr_arbiter

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: expected grants queued on stimulus, checked on en_sel.
module tb_bus_rr_arbiter;
  import bus_rr_arbiter_pkg::*;

  localparam int N  = 15;
  localparam int SW = 8;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.N_BUS(N), .SEL_W(SW)) bus ();

  bus_rr_arbiter #(
    .N_BUS   (N),
    .SEL_W   (SW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [SW-1:0] exp_q[$];
  logic          prev_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Grant monitor: every en_sel pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.en_sel === 1'b1) begin
      check("en_sel_one_cycle", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) check("grant_unexpected", 32'(bus.en_sel), 32'd0);
      else check("grant_sel", 32'(bus.sel), 32'(exp_q.pop_front()));
    end
    prev_en <= bus.en_sel;
  end

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.en_sel !== 1'b1 && n < 6);
    check({tag, "_grant"}, 32'(bus.en_sel), 32'd1);
  endtask

  task automatic release_done(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    check({tag, "_busy_rel"}, 32'(bus.busy), 32'd0);
    check({tag, "_terr_rel"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req  = '0;
    bus.done = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_en_sel", 32'(bus.en_sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);

    // Single request on channel 2, released by done three cycles after the grant
    rst     = 1'b0;
    bus.req = 15'h0004;
    exp_q.push_back(8'd2);
    wait_grant("t1");
    bus.req = '0;
    check("t1_busy_grant", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t1_en_drop", 32'(bus.en_sel), 32'd0);
    check("t1_busy_wait", 32'(bus.busy), 32'd1);
    release_done("t1", 2);
    check("t1_sel_hold", 32'(bus.sel), 32'd2);

    // All channels requesting: full rotation from 0 with wrap back to 0
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 15'h7FFF;
    for (int i = 0; i < 16; i++) exp_q.push_back(SW'(i % N));
    for (int k = 0; k < 16; k++) begin
      wait_grant("t2");
      if (k == 15) bus.req = '0;
      release_done("t2", 2);
    end

    // Timeout on channel 5, then re-grant of the same channel
    bus.req = 15'h0020;
    exp_q.push_back(8'd5);
    wait_grant("t3");
    bus.req = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy === 1'b1 && n < TO + 20);
    check("t3_wait_len", 32'(n), 32'(TO + 1));
    check("t3_terr", 32'(bus.timeout_err), 32'd1);
    check("t3_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t3_terr_pulse", 32'(bus.timeout_err), 32'd0);
    bus.req = 15'h0020;
    exp_q.push_back(8'd5);
    wait_grant("t3b");
    bus.req = '0;
    release_done("t3b", 1);

    // done on the final timeout cycle wins: no timeout_err
    bus.req = 15'h0100;
    exp_q.push_back(8'd8);
    wait_grant("t4");
    bus.req = '0;
    repeat (TO) @(negedge clk);
    check("t4_busy_pre", 32'(bus.busy), 32'd1);
    release_done("t4", 0);
    @(negedge clk);
    check("t4_terr_after", 32'(bus.timeout_err), 32'd0);

    // Reset mid-WAIT with sel=9, then re-grant; req changes in WAIT ignored
    bus.req = 15'h0200;
    exp_q.push_back(8'd9);
    wait_grant("t5");
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("t5_sel_wait", 32'(bus.sel), 32'd9);
    check("t5_busy_wait", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_sel", 32'(bus.sel), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_en", 32'(bus.en_sel), 32'd0);
    check("t5_rst_terr", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 15'h0200;
    exp_q.push_back(8'd9);
    wait_grant("t5b");
    bus.req = 15'h7FFF;
    @(negedge clk);
    check("t5_req_ign_sel", 32'(bus.sel), 32'd9);
    bus.req = 15'h0001;
    @(negedge clk);
    check("t5_req_ign_sel2", 32'(bus.sel), 32'd9);
    check("t5_req_ign_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    release_done("t5b", 1);

    // done ignored in IDLE and in GRANT
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_en", 32'(bus.en_sel), 32'd0);
    bus.req = 15'h0001;
    exp_q.push_back(8'd0);
    wait_grant("t6");
    bus.done = 1'b1;
    bus.req  = '0;
    @(negedge clk);
    bus.done = 1'b0;
    check("t6_grant_busy", 32'(bus.busy), 32'd1);
    check("t6_grant_en", 32'(bus.en_sel), 32'd0);
    @(negedge clk);
    check("t6_grant_busy2", 32'(bus.busy), 32'd1);
    release_done("t6", 1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_rr_arbiter
